// File: rtl/maxpool_window9_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_window9_gen_pkg
// Description : Shared constants and helpers for the SPPF 9x9 max-pool path
//               (window generator, max unit, SPPF controller).
//               K            : window edge length (9)
//               PAD          : border padding on each side (4)
//               FP16_NEG_INF : FP16 -inf, the neutral element for max
//               win_idx(r,c) : flattened window element index k = r*9 + c
// Revision    : 1.0 - initial release
// ============================================================================
package maxpool_window9_gen_pkg;

   localparam int K              = 9;
   localparam int PAD            = 4;
   localparam int DATA_WIDTH_DEF = 16;
   localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } mwg_state_e;

   // Element k of a flattened window lives at bits [DW*k +: DW].
   function automatic int win_idx(input int r, input int c);
      return r * K + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_window9_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mwg_line_buffer
// Description : Single-row delay line of DEPTH entries with shift enable.
//               dout is the sample written DEPTH enabled cycles earlier,
//               i.e. the same column of the previous padded row.
//               Written as a plain shift chain so it maps onto SRLs.
// Ports       : clk  - clock
//               en   - shift enable (one padded position consumed)
//               din  - new sample
//               dout - sample delayed by DEPTH enabled shifts
// Revision    : 1.0 - initial release
// ============================================================================
module mwg_line_buffer
   import maxpool_window9_gen_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 28
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   // No reset: contents are fully overwritten by top padding before use.
   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_d;

   always_comb begin
      mem_d = mem_q;
      if (en) begin
         mem_d = {mem_q[DEPTH-2:0], din};
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout = mem_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/maxpool_window9_gen.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_window9_gen
// Description : Streaming 9x9 window generator for the SPPF max-pool unit.
//               Scans a virtual (IMG_H+8)x(IMG_W+8) padded grid; in-image
//               positions consume one raster-order pixel, border positions
//               inject PAD_VALUE. Emits one flattened window per image
//               pixel (stride 1, same size).
// Ports       : clk, rst               - clock, sync active-high reset
//               in_valid/in_ready/in_data   - pixel input handshake
//               out_valid/out_ready/out_window/out_last - window output,
//                 element k=r*9+c at bits [DW*k +: DW], out_last marks the
//                 final window of a frame
//               stall_cnt              - (MWG_PERF_CNT_EN only) saturating
//                 count of cycles with out_valid && !out_ready
// Options     : define MWG_PERF_CNT_EN to add the stall_cnt port
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_window9_gen
   import maxpool_window9_gen_pkg::*;
#(
   parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int                    IMG_W      = 20,
   parameter int                    IMG_H      = 20,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = DATA_WIDTH'(FP16_NEG_INF)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH*81-1:0] out_window,
   output logic                     out_last
`ifdef MWG_PERF_CNT_EN
   ,
   output logic [31:0]              stall_cnt
`endif
);

   localparam int c_wp = IMG_W + 2 * PAD;
   localparam int c_hp = IMG_H + 2 * PAD;
   localparam int c_cw = $clog2(c_wp);
   localparam int c_rw = $clog2(c_hp);
   localparam int c_nw = DATA_WIDTH * K * K;

   localparam logic [c_cw-1:0] c_col_lo   = c_cw'(PAD);
   localparam logic [c_cw-1:0] c_col_hi   = c_cw'(IMG_W + PAD);
   localparam logic [c_cw-1:0] c_col_last = c_cw'(c_wp - 1);
   localparam logic [c_cw-1:0] c_col_win  = c_cw'(K - 1);
   localparam logic [c_rw-1:0] c_row_lo   = c_rw'(PAD);
   localparam logic [c_rw-1:0] c_row_hi   = c_rw'(IMG_H + PAD);
   localparam logic [c_rw-1:0] c_row_img  = c_rw'(IMG_H + PAD - 1);
   localparam logic [c_rw-1:0] c_row_last = c_rw'(c_hp - 1);
   localparam logic [c_rw-1:0] c_row_win  = c_rw'(K - 1);

   logic [c_rw-1:0] srow_q, srow_d;
   logic [c_cw-1:0] scol_q, scol_d;
   mwg_state_e      state_q, state_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic [c_nw-1:0] win_q, win_d;

   logic                            inimg;
   logic                            out_free;
   logic                            adv;
   logic                            win_here;
   logic                            past_img;
   logic [DATA_WIDTH-1:0]           sample;
   logic [K-2:0][DATA_WIDTH-1:0]    lb_in;
   logic [K-2:0][DATA_WIDTH-1:0]    tap;
   logic [K-1:0][DATA_WIDTH-1:0]    new_col;

   assign inimg    = (srow_q >= c_row_lo) && (srow_q < c_row_hi) &&
                     (scol_q >= c_col_lo) && (scol_q < c_col_hi);
   assign out_free = !out_valid_q || out_ready;
   assign adv      = (!inimg || in_valid) && out_free;
   assign in_ready = inimg && out_free && (state_q == ST_RUN) && !rst;
   assign sample   = inimg ? in_data : PAD_VALUE;

   // tap[i] is the sample (i+1) padded rows above the current position.
   generate
      for (genvar i = 0; i < K - 1; i++) begin : g_lb
         if (i == 0) begin : g_head
            assign lb_in[i] = sample;
         end else begin : g_link
            assign lb_in[i] = tap[i-1];
         end
         mwg_line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (c_wp)
         ) u_lb (
            .clk  (clk),
            .en   (adv),
            .din  (lb_in[i]),
            .dout (tap[i])
         );
      end
   endgenerate

   // New right column, top row (oldest) first; bottom row is the live sample.
   always_comb begin
      new_col = '0;
      for (int r = 0; r < K - 1; r++) begin
         new_col[r] = tap[K-2-r];
      end
      new_col[K-1] = sample;
   end

   always_comb begin
      win_d = win_q;
      if (adv) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               win_d[win_idx(r, c) * DATA_WIDTH +: DATA_WIDTH] =
                  win_q[win_idx(r, c + 1) * DATA_WIDTH +: DATA_WIDTH];
            end
            win_d[win_idx(r, K - 1) * DATA_WIDTH +: DATA_WIDTH] = new_col[r];
         end
      end
   end

   // Window after this shift is complete once the scan has covered 9 rows
   // and 9 columns of the padded grid (bottom-right corner at the sample).
   assign win_here = (srow_q >= c_row_win) && (scol_q >= c_col_win);

   always_comb begin
      srow_d      = srow_q;
      scol_d      = scol_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      if (adv) begin
         if (scol_q == c_col_last) begin
            scol_d = '0;
            srow_d = (srow_q == c_row_last) ? '0 : srow_q + 1'b1;
         end else begin
            scol_d = scol_q + 1'b1;
         end
         out_valid_d = win_here;
         out_last_d  = win_here && (srow_q == c_row_last) && (scol_q == c_col_last);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   // Next position lies beyond the final in-image pixel of the frame.
   assign past_img = (srow_d > c_row_img) ||
                     ((srow_d == c_row_img) && (scol_d >= c_col_hi));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (adv && past_img) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (adv && (srow_d == '0) && (scol_d == '0)) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         srow_q      <= '0;
         scol_q      <= '0;
         state_q     <= ST_RUN;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         srow_q      <= srow_d;
         scol_q      <= scol_d;
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   // Window data is not reset: it is refilled before out_valid can rise.
   always_ff @(posedge clk) begin
      win_q <= win_d;
   end

   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign out_window = win_q;

`ifdef MWG_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
